swap_datapath: RTL and testbench

SWAP_DATAPATH -- requirements
Module: swap_datapath

---
 rtl/swap_datapath_if.sv | 24 ++
 rtl/swap_datapath.sv | 120 ++++++++++++
 tb/tb_swap_datapath.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/swap_datapath_if.sv
// Bus/control bundle between the swap controller and the three-register swap datapath.
interface swap_datapath_if #(parameter int N = 8);
    logic [N-1:0] Data;
    logic         Extern;
    logic         R1in, R2in, R3in;
    logic         R1out, R2out, R3out;
    logic         Done;
    logic [N-1:0] BusWires;
    logic [N-1:0] R1, R2, R3;
    logic         BusErr;
    logic         SeqErr;
    logic         Busy;
    logic [7:0]   SwapCount;

    modport master (
        output Data, Extern, R1in, R2in, R3in, R1out, R2out, R3out, Done,
        input  BusWires, R1, R2, R3, BusErr, SeqErr, Busy, SwapCount
    );

    modport slave (
        input  Data, Extern, R1in, R2in, R3in, R1out, R2out, R3out, Done,
        output BusWires, R1, R2, R3, BusErr, SeqErr, Busy, SwapCount
    );
endinterface

// File: rtl/swap_datapath.sv
// Shared-bus three-register swap datapath with bus-conflict detection and a
// checker that counts well-formed R1<->R2 swaps (via R3) and flags bad sequences.
module swap_datapath #(
    parameter int N = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    swap_datapath_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] T1   = 2'd1;
    localparam logic [1:0] T2   = 2'd2;

    // Control vector order: {R1in, R2in, R3in, R1out, R2out, R3out}
    localparam logic [5:0] STEP1 = 6'b001_010;
    localparam logic [5:0] STEP2 = 6'b010_100;
    localparam logic [5:0] STEP3 = 6'b100_001;

    logic [N-1:0] r1, r2, r3;
    logic [N-1:0] buswires;
    logic [3:0]   srcs;
    logic [5:0]   ctrl;
    logic         conflict;
    logic         transfer;
    logic         ext_load;
    logic         buserr;
    logic         seqerr, seqerr_nxt;
    logic         inc;
    logic [1:0]   state, state_nxt;
    logic [7:0]   swapcount;

    assign srcs     = {bus.Extern, bus.R1out, bus.R2out, bus.R3out};
    assign ctrl     = {bus.R1in, bus.R2in, bus.R3in, bus.R1out, bus.R2out, bus.R3out};
    // More than one bit set in srcs.
    assign conflict = |(srcs & (srcs - 4'd1));
    assign transfer = |ctrl;
    assign ext_load = bus.Extern && !(bus.R1out || bus.R2out || bus.R3out);

    always_comb begin
        buswires = '0;
        if (!conflict) begin
            buswires = ({N{bus.Extern}} & bus.Data) |
                       ({N{bus.R1out}}  & r1)       |
                       ({N{bus.R2out}}  & r2)       |
                       ({N{bus.R3out}}  & r3);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r1     <= '0;
            r2     <= '0;
            r3     <= '0;
            buserr <= 1'b0;
        end else if (conflict) begin
            buserr <= 1'b1;
        end else begin
            if (bus.R1in) r1 <= buswires;
            if (bus.R2in) r2 <= buswires;
            if (bus.R3in) r3 <= buswires;
        end
    end

    // A conflict can never match an exact step, so it falls into the error paths.
    always_comb begin
        state_nxt  = state;
        seqerr_nxt = 1'b0;
        inc        = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl == STEP1 && !bus.Extern && !bus.Done) begin
                    state_nxt = T1;
                end else if (!((ext_load || !transfer) && !bus.Done)) begin
                    seqerr_nxt = 1'b1;
                end
            end
            T1: begin
                if (ctrl == STEP2 && !bus.Extern && !bus.Done) begin
                    state_nxt = T2;
                end else begin
                    state_nxt  = IDLE;
                    seqerr_nxt = 1'b1;
                end
            end
            T2: begin
                state_nxt = IDLE;
                if (ctrl == STEP3 && !bus.Extern && bus.Done) begin
                    inc = 1'b1;
                end else begin
                    seqerr_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                seqerr_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            seqerr    <= 1'b0;
            swapcount <= '0;
        end else begin
            state  <= state_nxt;
            seqerr <= seqerr_nxt;
            if (inc) swapcount <= swapcount + 8'd1;
        end
    end

    assign bus.BusWires  = buswires;
    assign bus.R1        = r1;
    assign bus.R2        = r2;
    assign bus.R3        = r3;
    assign bus.BusErr    = buserr;
    assign bus.SeqErr    = seqerr;
    assign bus.Busy      = (state != IDLE);
    assign bus.SwapCount = swapcount;
endmodule

// File: tb/tb_swap_datapath.sv
// Directed self-checking bench for swap_datapath: loads, swaps, conflicts, sequence errors, reset.
module tb_swap_datapath;
    logic Clock;
    logic Reset;
    int unsigned n_checks;
    int unsigned n_pass;
    logic seq_seen;

    swap_datapath_if #(.N(8)) b ();

    swap_datapath #(.N(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (b)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // c = {R1in, R2in, R3in, R1out, R2out, R3out}
    task automatic drive(input logic ext, input logic [7:0] d, input logic [5:0] c, input logic dn);
        b.Extern = ext;
        b.Data   = d;
        {b.R1in, b.R2in, b.R3in, b.R1out, b.R2out, b.R3out} = c;
        b.Done   = dn;
    endtask

    // Apply one cycle of controls, then return to an empty bus just after the edge.
    task automatic step(input logic ext, input logic [7:0] d, input logic [5:0] c, input logic dn);
        drive(ext, d, c, dn);
        @(posedge Clock);
        #1;
        drive(1'b0, 8'h00, 6'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        #2 Reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b1;
        drive(1'b0, 8'h00, 6'b0, 1'b0);
        #3;
        check("rst_r1", b.R1, 0);
        check("rst_r2", b.R2, 0);
        check("rst_r3", b.R3, 0);
        check("rst_buserr", b.BusErr, 0);
        check("rst_seqerr", b.SeqErr, 0);
        check("rst_count", b.SwapCount, 0);
        check("rst_busy", b.Busy, 0);
        @(posedge Clock);
        #2 Reset = 1'b0;
        @(posedge Clock);
        #1;

        // External loads
        step(1'b1, 8'h11, 6'b100_000, 1'b0);
        step(1'b1, 8'h22, 6'b010_000, 1'b0);
        check("ext_r1", b.R1, 8'h11);
        check("ext_r2", b.R2, 8'h22);
        check("ext_seqerr", b.SeqErr, 0);
        check("ext_busy", b.Busy, 0);
        drive(1'b1, 8'h5A, 6'b0, 1'b0);
        #1 check("bus_comb_ext", b.BusWires, 8'h5A);
        drive(1'b0, 8'h00, 6'b000_010, 1'b0);
        #1 check("bus_comb_r2", b.BusWires, 8'h22);
        drive(1'b0, 8'h00, 6'b0, 1'b0);
        #1 check("bus_idle", b.BusWires, 8'h00);

        // Legal swap
        step(1'b0, 8'h00, 6'b001_010, 1'b0);
        check("sw1_busy", b.Busy, 1);
        check("sw1_r3", b.R3, 8'h22);
        step(1'b0, 8'h00, 6'b010_100, 1'b0);
        check("sw2_busy", b.Busy, 1);
        check("sw2_r2", b.R2, 8'h11);
        step(1'b0, 8'h00, 6'b100_001, 1'b1);
        check("sw3_busy", b.Busy, 0);
        check("sw3_r1", b.R1, 8'h22);
        check("sw3_r2", b.R2, 8'h11);
        check("sw3_r3", b.R3, 8'h22);
        check("sw3_count", b.SwapCount, 1);
        check("sw3_seqerr", b.SeqErr, 0);

        // Empty cycle inside a swap (R3 picks up R2 = 0x11)
        step(1'b0, 8'h00, 6'b001_010, 1'b0);
        check("gap_busy1", b.Busy, 1);
        step(1'b0, 8'h00, 6'b0, 1'b0);
        check("gap_seqerr", b.SeqErr, 1);
        check("gap_busy", b.Busy, 0);
        check("gap_count", b.SwapCount, 1);
        step(1'b0, 8'h00, 6'b0, 1'b0);
        check("gap_pulse_end", b.SeqErr, 0);

        // Done while idle
        step(1'b0, 8'h00, 6'b0, 1'b1);
        check("done_idle_seqerr", b.SeqErr, 1);
        step(1'b0, 8'h00, 6'b0, 1'b0);
        check("done_idle_clear", b.SeqErr, 0);

        // Self-reload is legal
        step(1'b0, 8'h00, 6'b100_100, 1'b0);
        check("selfload_r1", b.R1, 8'h22);
        check("selfload_seqerr", b.SeqErr, 1);
        check("selfload_buserr", b.BusErr, 0);

        // Conflict: Extern + R1out with R2in
        drive(1'b1, 8'h77, 6'b010_100, 1'b0);
        #1 check("conf_bus", b.BusWires, 8'h00);
        @(posedge Clock);
        #1 drive(1'b0, 8'h00, 6'b0, 1'b0);
        check("conf_r2", b.R2, 8'h11);
        check("conf_buserr", b.BusErr, 1);
        repeat (10) step(1'b0, 8'h00, 6'b0, 1'b0);
        check("conf_sticky", b.BusErr, 1);

        // Conflict during T1 is a sequence error
        step(1'b0, 8'h00, 6'b001_010, 1'b0);
        step(1'b1, 8'h33, 6'b010_100, 1'b0);
        check("conf_t1_seqerr", b.SeqErr, 1);
        check("conf_t1_busy", b.Busy, 0);

        // Asynchronous reset in T2
        step(1'b0, 8'h00, 6'b0, 1'b0);
        step(1'b0, 8'h00, 6'b001_010, 1'b0);
        step(1'b0, 8'h00, 6'b010_100, 1'b0);
        check("t2_busy", b.Busy, 1);
        #2 Reset = 1'b1;
        #1;
        check("arst_r1", b.R1, 0);
        check("arst_r2", b.R2, 0);
        check("arst_r3", b.R3, 0);
        check("arst_buserr", b.BusErr, 0);
        check("arst_seqerr", b.SeqErr, 0);
        check("arst_busy", b.Busy, 0);
        check("arst_count", b.SwapCount, 0);
        #1 Reset = 1'b0;
        @(posedge Clock);
        #1;
        step(1'b1, 8'h11, 6'b100_000, 1'b0);
        step(1'b1, 8'h22, 6'b010_000, 1'b0);
        step(1'b0, 8'h00, 6'b001_010, 1'b0);
        step(1'b0, 8'h00, 6'b010_100, 1'b0);
        step(1'b0, 8'h00, 6'b100_001, 1'b1);
        check("post_rst_count", b.SwapCount, 1);
        check("post_rst_r1", b.R1, 8'h22);
        check("post_rst_seqerr", b.SeqErr, 0);

        // 256 swaps wrap the counter
        do_reset();
        seq_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 8'h00, 6'b001_010, 1'b0);
            seq_seen |= b.SeqErr;
            step(1'b0, 8'h00, 6'b010_100, 1'b0);
            seq_seen |= b.SeqErr;
            step(1'b0, 8'h00, 6'b100_001, 1'b1);
            seq_seen |= b.SeqErr;
            if (i == 254) check("wrap_255", b.SwapCount, 255);
        end
        check("wrap_count", b.SwapCount, 0);
        check("wrap_seqerr", seq_seen, 0);
        check("wrap_buserr", b.BusErr, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
